// File: rtl/regfile_sb.sv
// regfile_sb: register file with a per-register pending-write scoreboard.
// Each register has a 2-bit counter of outstanding writebacks. The issue
// stage reserves a destination. Writeback retires the reservation.
// Protocol violations (overflow, or writeback with nothing pending) raise a
// sticky sb_err flag.
// Optional feature: define REGFILE_BYPASS_EN to forward writeback data
// straight to the read ports in the same cycle.
module regfile_sb #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(DEPTH)-1:0] ra1,
  input  logic [$clog2(DEPTH)-1:0] ra2,
  output logic [WIDTH-1:0]         rd1,
  output logic [WIDTH-1:0]         rd2,
  output logic                     busy1,
  output logic                     busy2,
  input  logic                     we3,
  input  logic [$clog2(DEPTH)-1:0] wa3,
  input  logic [WIDTH-1:0]         wd3,
  input  logic                     rsv_en,
  input  logic [$clog2(DEPTH)-1:0] rsv_addr,
  output logic                     rsv_full,
  output logic                     sb_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ZA = AW'(ZERO_REG);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [1:0]       cnt  [DEPTH];

  logic rsv_ok;
  logic wr_ok;
  logic same_reg;
  logic err_set;

  // Qualify the reservation and writeback requests and detect protocol errors.
  // A reservation and a writeback to the same register cancel out, so
  // neither can raise an error.
  always_comb begin
    rsv_ok   = rsv_en && (rsv_addr != ZA);
    wr_ok    = we3 && (wa3 != ZA);
    same_reg = rsv_ok && wr_ok && (rsv_addr == wa3);
    err_set  = !same_reg &&
               ((rsv_ok && (cnt[rsv_addr] == 2'd3)) ||
                (wr_ok  && (cnt[wa3] == 2'd0)));
  end

  // Register storage, pending counters and the sticky error flag.
  // Reset loads each register with its own index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= (i == ZERO_REG) ? '0 : WIDTH'(i);
        cnt[i]  <= 2'd0;
      end
      sb_err <= 1'b0;
    end else begin
      if (wr_ok)
        regs[wa3] <= wd3;
      // Here the two targets are distinct, so the two counter updates never collide.
      if (!same_reg) begin
        if (rsv_ok && (cnt[rsv_addr] != 2'd3))
          cnt[rsv_addr] <= cnt[rsv_addr] + 2'd1;
        if (wr_ok && (cnt[wa3] != 2'd0))
          cnt[wa3] <= cnt[wa3] - 2'd1;
      end
      if (err_set)
        sb_err <= 1'b1;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp1;
  logic byp2;

  // Read ports with same-cycle writeback forwarding.
  // A forwarded read retires its last pending write, so busy drops early.
  always_comb begin
    byp1  = !reset && we3 && (wa3 == ra1) && (ra1 != ZA);
    byp2  = !reset && we3 && (wa3 == ra2) && (ra2 != ZA);
    rd1   = (ra1 == ZA) ? '0 : (byp1 ? wd3 : regs[ra1]);
    rd2   = (ra2 == ZA) ? '0 : (byp2 ? wd3 : regs[ra2]);
    busy1 = (ra1 != ZA) && (cnt[ra1] != 2'd0) && !(byp1 && (cnt[ra1] == 2'd1));
    busy2 = (ra2 != ZA) && (cnt[ra2] != 2'd0) && !(byp2 && (cnt[ra2] == 2'd1));
  end
`else
  // Read ports show only state registered before the current edge.
  always_comb begin
    rd1   = (ra1 == ZA) ? '0 : regs[ra1];
    rd2   = (ra2 == ZA) ? '0 : regs[ra2];
    busy1 = (ra1 != ZA) && (cnt[ra1] != 2'd0);
    busy2 = (ra2 != ZA) && (cnt[ra2] != 2'd0);
  end
`endif

  assign rsv_full = (cnt[rsv_addr] == 2'd3);

endmodule

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb, using default parameters
// (64-bit, 32 registers, zero register 31).
module tb_regfile_sb;

  logic        clk;
  logic        reset;
  logic [4:0]  ra1, ra2, wa3, rsv_addr;
  logic [63:0] rd1, rd2, wd3;
  logic        busy1, busy2, we3, rsv_en, rsv_full, sb_err;

  int checks;
  int failures;

  regfile_sb dut (
    .clk(clk), .reset(reset),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_full(rsv_full), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ra1, ra2;
    logic        we3;
    logic [4:0]  wa3;
    logic [63:0] wd3;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [63:0] e_rd1, e_rd2;
    logic        e_b1, e_b2, e_full, e_err;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input logic [4:0] a1, input logic [4:0] a2,
                              input logic w, input logic [4:0] wa, input logic [63:0] wd,
                              input logic r, input logic [4:0] radr,
                              input logic [63:0] e1, input logic [63:0] e2,
                              input logic b1, input logic b2, input logic f, input logic e);
    vec_t v;
    v.ra1 = a1; v.ra2 = a2; v.we3 = w; v.wa3 = wa; v.wd3 = wd;
    v.rsv_en = r; v.rsv_addr = radr;
    v.e_rd1 = e1; v.e_rd2 = e2; v.e_b1 = b1; v.e_b2 = b2; v.e_full = f; v.e_err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, settle before the rising edge.
  task automatic drv(input logic w, input logic [4:0] wa, input logic [63:0] wd,
                     input logic r, input logic [4:0] radr,
                     input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    we3 = w; wa3 = wa; wd3 = wd; rsv_en = r; rsv_addr = radr; ra1 = a1; ra2 = a2;
    #2;
  endtask

  // Asynchronous reset pulse inside the low clock phase.
  task automatic pulse_reset();
    @(negedge clk);
    we3 = 1'b0; rsv_en = 1'b0;
    #1 reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    we3 = 1'b0; wa3 = '0; wd3 = '0; rsv_en = 1'b0; rsv_addr = '0;
    ra1 = 5'd5; ra2 = 5'd31;

    tbl[0]  = mk(5, 31, 0, 0,  64'h0,    0, 0,  64'd5,    64'd0,    0, 0, 0, 0);
    tbl[1]  = mk(3, 0,  0, 0,  64'h0,    1, 3,  64'd3,    64'd0,    0, 0, 0, 0);
    tbl[2]  = mk(3, 0,  0, 0,  64'h0,    0, 3,  64'd3,    64'd0,    1, 0, 0, 0);
    tbl[3]  = mk(1, 2,  1, 3,  64'hDEAD, 0, 0,  64'd1,    64'd2,    0, 0, 0, 0);
    tbl[4]  = mk(3, 0,  0, 0,  64'h0,    0, 0,  64'hDEAD, 64'd0,    0, 0, 0, 0);
    tbl[5]  = mk(5, 6,  1, 4,  64'h1234, 1, 4,  64'd5,    64'd6,    0, 0, 0, 0);
    tbl[6]  = mk(4, 4,  0, 0,  64'h0,    0, 4,  64'h1234, 64'h1234, 0, 0, 0, 0);
    tbl[7]  = mk(31, 0, 1, 31, 64'hFFFF, 0, 0,  64'd0,    64'd0,    0, 0, 0, 0);
    tbl[8]  = mk(31, 30, 0, 0, 64'h0,    0, 0,  64'd0,    64'd30,   0, 0, 0, 0);
    tbl[9]  = mk(10, 0, 0, 0,  64'h0,    1, 10, 64'd10,   64'd0,    0, 0, 0, 0);
    tbl[10] = mk(11, 12, 1, 10, 64'hA,   1, 11, 64'd11,   64'd12,   0, 0, 0, 0);
    tbl[11] = mk(10, 11, 0, 0, 64'h0,    0, 0,  64'hA,    64'd11,   0, 1, 0, 0);
    tbl[12] = mk(0, 1,  1, 11, 64'hB,    0, 0,  64'd0,    64'd1,    0, 0, 0, 0);
    tbl[13] = mk(11, 0, 0, 0,  64'h0,    0, 0,  64'hB,    64'd0,    0, 0, 0, 0);

    // Values visible while reset is held, with a write attempted.
    we3 = 1'b1; wa3 = 5'd5; wd3 = 64'h99;
    @(posedge clk); #1;
    we3 = 1'b0;
    #1;
    chk("reset_rd1", rd1, 64'd5);
    chk("reset_rd2", rd2, 64'd0);
    chk("reset_busy1", {63'd0, busy1}, 64'd0);
    chk("reset_full", {63'd0, rsv_full}, 64'd0);
    chk("reset_err", {63'd0, sb_err}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drv(tbl[i].we3, tbl[i].wa3, tbl[i].wd3, tbl[i].rsv_en, tbl[i].rsv_addr,
          tbl[i].ra1, tbl[i].ra2);
      chk($sformatf("v%0d_rd1", i), rd1, tbl[i].e_rd1);
      chk($sformatf("v%0d_rd2", i), rd2, tbl[i].e_rd2);
      chk($sformatf("v%0d_busy1", i), {63'd0, busy1}, {63'd0, tbl[i].e_b1});
      chk($sformatf("v%0d_busy2", i), {63'd0, busy2}, {63'd0, tbl[i].e_b2});
      chk($sformatf("v%0d_full", i), {63'd0, rsv_full}, {63'd0, tbl[i].e_full});
      chk($sformatf("v%0d_err", i), {63'd0, sb_err}, {63'd0, tbl[i].e_err});
    end

    // Same-cycle forwarding on reg 9 with one pending write.
    drv(0, 0, 0, 1, 9, 0, 9);
    drv(1, 9, 64'h55, 0, 0, 0, 9);
`ifdef REGFILE_BYPASS_EN
    chk("byp_rd2", rd2, 64'h55);
    chk("byp_busy2", {63'd0, busy2}, 64'd0);
`else
    chk("byp_rd2", rd2, 64'd9);
    chk("byp_busy2", {63'd0, busy2}, 64'd1);
`endif
    drv(0, 0, 0, 0, 0, 0, 9);
    chk("byp_after_rd2", rd2, 64'h55);
    chk("byp_after_busy2", {63'd0, busy2}, 64'd0);

    // Mid-cycle reset cancels two pending reservations on reg 12.
    drv(0, 0, 0, 1, 12, 12, 5);
    drv(0, 0, 0, 1, 12, 12, 5);
    drv(0, 0, 0, 0, 12, 12, 5);
    chk("r12_busy_pre", {63'd0, busy1}, 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("r12_busy_rst", {63'd0, busy1}, 64'd0);
    chk("r12_rd_rst", rd1, 64'd12);
    chk("r12_rd2_rst", rd2, 64'd5);
    chk("r12_err_rst", {63'd0, sb_err}, 64'd0);
    rsv_en = 1'b1; we3 = 1'b1; wa3 = 5'd12; wd3 = 64'h77;
    #1;
    chk("r12_rd_rst_wr", rd1, 64'd12);
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0; rsv_en = 1'b0; we3 = 1'b0;
    #2;
    chk("r12_busy_post", {63'd0, busy1}, 64'd0);
    chk("r12_rd_post", rd1, 64'd12);
    chk("r12_err_post", {63'd0, sb_err}, 64'd0);

    // Counter at 3: simultaneous reserve and write on reg 6 is a no-op, no error.
    drv(0, 0, 0, 1, 6, 0, 0);
    drv(0, 0, 0, 1, 6, 0, 0);
    drv(0, 0, 0, 1, 6, 0, 0);
    drv(0, 0, 0, 0, 6, 6, 0);
    chk("r6_full", {63'd0, rsv_full}, 64'd1);
    chk("r6_busy", {63'd0, busy1}, 64'd1);
    drv(1, 6, 64'h66, 1, 6, 0, 0);
    drv(0, 0, 0, 0, 6, 6, 0);
    chk("r6_full_after", {63'd0, rsv_full}, 64'd1);
    chk("r6_err_after", {63'd0, sb_err}, 64'd0);
    chk("r6_rd_after", rd1, 64'h66);

    // Overflow on reg 7.
    drv(0, 0, 0, 1, 7, 0, 0);
    drv(0, 0, 0, 1, 7, 0, 0);
    drv(0, 0, 0, 1, 7, 0, 0);
    drv(0, 0, 0, 0, 7, 7, 0);
    chk("r7_full", {63'd0, rsv_full}, 64'd1);
    chk("r7_err_pre", {63'd0, sb_err}, 64'd0);
    drv(0, 0, 0, 1, 7, 0, 0);
    drv(0, 0, 0, 0, 7, 7, 0);
    chk("r7_full_ovf", {63'd0, rsv_full}, 64'd1);
    chk("r7_err_ovf", {63'd0, sb_err}, 64'd1);
    drv(1, 7, 64'h70, 0, 0, 0, 0);
    drv(1, 7, 64'h71, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 7, 7, 0);
    chk("r7_busy_two_wr", {63'd0, busy1}, 64'd1);
    drv(1, 7, 64'h72, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 7, 7, 0);
    chk("r7_busy_three_wr", {63'd0, busy1}, 64'd0);
    chk("r7_full_three_wr", {63'd0, rsv_full}, 64'd0);
    chk("r7_rd", rd1, 64'h72);

    // Writeback with nothing pending: data lands, error set, counter stays 0.
    pulse_reset();
    #1;
    chk("r8_err_cleared", {63'd0, sb_err}, 64'd0);
    drv(1, 8, 64'h88, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 8, 8, 0);
    chk("r8_rd", rd1, 64'h88);
    chk("r8_busy", {63'd0, busy1}, 64'd0);
    chk("r8_full", {63'd0, rsv_full}, 64'd0);
    chk("r8_err", {63'd0, sb_err}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
